// File: rtl/display_scanner.sv
// Multiplexed common-anode hex display driver: steps one digit per synchronized
// scan_in rising edge and latches value/dp once per frame when digit 0 comes up.
module display_scanner #(
    parameter int DIGITS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_in,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segments,
    output logic                  seg_dp,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{POL}};
    localparam logic [6:0]        SEG_OFF = {7{POL}};

    logic s1, s2, s3;
    logic step, advance, wrap;

    logic [IW-1:0]       index, index_nxt;
    logic [4*DIGITS-1:0] shadow_value, shadow_value_nxt;
    logic [DIGITS-1:0]   shadow_dp, shadow_dp_nxt;

    logic [3:0]          nib;
    logic [DIGITS-1:0]   upper_zero;
    logic                blank;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   an_on;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'ha: hex7 = 7'b1110111;
            4'hb: hex7 = 7'b1111100;
            4'hc: hex7 = 7'b0111001;
            4'hd: hex7 = 7'b1011110;
            4'he: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign step    = s2 & ~s3;
    assign advance = step & enable;
    assign wrap    = advance & (index == LAST);

    // Display is computed from the post-step index and shadow so the outputs
    // change on the same edge as the index, including the frame-latch edge.
    always_comb begin
        index_nxt        = index;
        shadow_value_nxt = shadow_value;
        shadow_dp_nxt    = shadow_dp;
        if (advance) begin
            index_nxt = (index == LAST) ? '0 : index + IW'(1);
        end
        if (wrap) begin
            shadow_value_nxt = value;
            shadow_dp_nxt    = dp;
        end
    end

    // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (shadow_value_nxt[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] & (shadow_value_nxt[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        nib    = shadow_value_nxt[4*index_nxt +: 4];
        blank  = (BLANK_LEADING != 0) && (index_nxt != '0) && upper_zero[index_nxt];
        seg_on = blank ? 7'b0000000 : hex7(nib);
        an_on  = DIGITS'(1) << index_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            index        <= LAST;
            shadow_value <= '0;
            shadow_dp    <= '0;
            anodes       <= AN_OFF;
            segments     <= SEG_OFF;
            seg_dp       <= POL;
            frame_start  <= 1'b0;
        end else begin
            s1           <= scan_in;
            s2           <= s1;
            s3           <= s2;
            index        <= index_nxt;
            shadow_value <= shadow_value_nxt;
            shadow_dp    <= shadow_dp_nxt;
            frame_start  <= wrap;
            // Disabled: blank at once; after re-enable stay blank until a step.
            if (!enable) begin
                anodes   <= AN_OFF;
                segments <= SEG_OFF;
                seg_dp   <= POL;
            end else if (step) begin
                anodes   <= an_on ^ AN_OFF;
                segments <= seg_on ^ SEG_OFF;
                seg_dp   <= shadow_dp_nxt[index_nxt] ^ POL;
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (4 digits, active-low, leading blanking): directed
// scan steps with hand-computed display words checked by a change-driven monitor.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_in;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        seg_dp;
    logic        frame_start;

    // Item layout: {anodes[3:0], segments[6:0], seg_dp, frame_start}
    localparam logic [12:0] INACT = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    logic [12:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          fs_seen = 0;
    int          fs_exp = 0;
    logic        mon_en = 1'b0;
    logic [11:0] prev;

    display_scanner #(.DIGITS(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .scan_in(scan_in), .enable(enable),
        .value(value), .dp(dp), .anodes(anodes), .segments(segments),
        .seg_dp(seg_dp), .frame_start(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic scan_step();
        scan_in = 1'b1;
        repeat (10) @(negedge clk);
        scan_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic expect_item(input logic [3:0] an, input logic [6:0] seg,
                               input logic sdp, input logic fs);
        exp_q.push_back({an, seg, sdp, fs});
        if (fs) fs_exp++;
    endtask

    // scoreboard monitor: one expected item per change of the visible display
    always @(negedge clk) begin
        if (mon_en) begin
            logic [12:0] cur;
            cur = {anodes, segments, seg_dp, frame_start};
            if (frame_start) fs_seen++;
            if (cur[12:1] != prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change: got %b expected no change", cur);
                end else begin
                    check("display_word", cur, exp_q.pop_front());
                end
                prev = cur[12:1];
            end
        end
    end

    initial begin
        reset   = 1'b1;
        scan_in = 1'b0;
        enable  = 1'b1;
        value   = 16'h1234;
        dp      = 4'b0000;
        do_reset();
        check("reset_state", {anodes, segments, seg_dp, frame_start}, INACT);
        prev   = INACT[12:1];
        mon_en = 1'b1;

        // 1234: one full frame plus the wrap into the next
        expect_item(4'b1110, 7'b0011001, 1'b1, 1'b1);
        expect_item(4'b1101, 7'b0110000, 1'b1, 1'b0);
        expect_item(4'b1011, 7'b0100100, 1'b1, 1'b0);
        expect_item(4'b0111, 7'b1111001, 1'b1, 1'b0);
        expect_item(4'b1110, 7'b0011001, 1'b1, 1'b1);
        repeat (5) scan_step();

        // latency: rise before edge k, change at k+2; long high = one step
        expect_item(4'b1101, 7'b0110000, 1'b1, 1'b0);
        scan_in = 1'b1;
        @(posedge clk); #1;
        check("lat_edge_k", {9'd0, anodes}, {9'd0, 4'b1110});
        @(posedge clk); #1;
        check("lat_edge_k1", {9'd0, anodes}, {9'd0, 4'b1110});
        @(posedge clk); #1;
        check("lat_edge_k2", {9'd0, anodes}, {9'd0, 4'b1101});
        repeat (50) @(negedge clk);
        check("long_high_one_step", {9'd0, anodes}, {9'd0, 4'b1101});
        scan_in = 1'b0;
        repeat (10) @(negedge clk);

        // mid-frame update at index 1: applies from the next frame only
        value = 16'hABCD;
        expect_item(4'b1011, 7'b0100100, 1'b1, 1'b0);
        expect_item(4'b0111, 7'b1111001, 1'b1, 1'b0);
        expect_item(4'b1110, 7'b0100001, 1'b1, 1'b1);
        expect_item(4'b1101, 7'b1000110, 1'b1, 1'b0);
        expect_item(4'b1011, 7'b0000011, 1'b1, 1'b0);
        expect_item(4'b0111, 7'b0001000, 1'b1, 1'b0);
        repeat (6) scan_step();

        // leading blanking with a decimal point on blanked digit 2
        value = 16'h0050;
        dp    = 4'b0100;
        expect_item(4'b1110, 7'b1000000, 1'b1, 1'b1);
        expect_item(4'b1101, 7'b0010010, 1'b1, 1'b0);
        expect_item(4'b1011, 7'b1111111, 1'b0, 1'b0);
        expect_item(4'b0111, 7'b1111111, 1'b1, 1'b0);
        repeat (4) scan_step();

        // enable low during digit 2
        expect_item(4'b1110, 7'b1000000, 1'b1, 1'b1);
        expect_item(4'b1101, 7'b0010010, 1'b1, 1'b0);
        expect_item(4'b1011, 7'b1111111, 1'b0, 1'b0);
        repeat (3) scan_step();
        exp_q.push_back(INACT);
        enable = 1'b0;
        @(posedge clk); #1;
        check("disable_next_edge", {anodes, segments, seg_dp, frame_start}, INACT);
        @(negedge clk);
        repeat (10) scan_step();
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("reenable_still_blank", {anodes, segments, seg_dp, frame_start}, INACT);
        expect_item(4'b0111, 7'b1111111, 1'b1, 1'b0);
        scan_step();

        // reset for one cycle at index 2
        expect_item(4'b1110, 7'b1000000, 1'b1, 1'b1);
        expect_item(4'b1101, 7'b0010010, 1'b1, 1'b0);
        expect_item(4'b1011, 7'b1111111, 1'b0, 1'b0);
        repeat (3) scan_step();
        exp_q.push_back(INACT);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_frame", {anodes, segments, seg_dp, frame_start}, INACT);
        @(negedge clk);
        reset = 1'b0;
        expect_item(4'b1110, 7'b1000000, 1'b1, 1'b1);
        scan_step();

        repeat (10) @(negedge clk);
        check("queue_drained", 13'(exp_q.size()), 13'd0);
        check("frame_start_count", 13'(fs_seen), 13'(fs_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
